register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 9 +
 rtl/register_file.sv | 55 +++++
 tb/tb_register_file.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared datapath constants: register file geometry and architecturally fixed register indices.
package register_file_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned REG_SEL_BITS_DEF = 5;

  localparam int unsigned ZERO_REG = 0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// 2**REG_SEL_BITS x DATA_WIDTH register file: one synchronous write port, two combinational
// read ports, register 0 hardwired to zero, asynchronous active-low clear of every entry.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned REG_SEL_BITS = REG_SEL_BITS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [REG_SEL_BITS-1:0] read_sel1,
  input  logic [REG_SEL_BITS-1:0] read_sel2,
  input  logic                    write,
  input  logic [REG_SEL_BITS-1:0] write_sel,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2
);

  localparam int unsigned NUM_REGS = 2 ** REG_SEL_BITS;
  localparam logic [REG_SEL_BITS-1:0] ZERO_SEL = REG_SEL_BITS'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    // NOTE: every always_comb output gets a full default first; a path that leaves it unassigned infers a latch.
    regs_d = regs_q;
    if (write && (write_sel != ZERO_SEL)) begin
      regs_d[write_sel] = write_data;
    end
    regs_d[ZERO_REG] = '0;
  end

  // NOTE: this storage array is deliberately reset; the datapath relies on every register reading 0 out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, giving old-data read-during-write.
      regs_q <= regs_d;
    end
  end

  // Read muxes force index 0 to zero independently of the stored value.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_sel1 != ZERO_SEL) read_data1 = regs_q[read_sel1];
    if (read_sel2 != ZERO_SEL) read_data2 = regs_q[read_sel2];
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, register 0, write enable,
// read-during-write and asynchronous reset, each checked against hand-computed values.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  read_sel1;
  logic [4:0]  read_sel2;
  logic        write;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int tests_run    = 0;
  int tests_failed = 0;

  register_file #(
    .DATA_WIDTH  (32),
    .REG_SEL_BITS(5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .read_sel1 (read_sel1),
    .read_sel2 (read_sel2),
    .write     (write),
    .write_sel (write_sel),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One write on the next rising edge; inputs change on the falling edge.
  task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
    @(negedge clock);
    write      = 1'b1;
    write_sel  = sel;
    write_data = data;
    @(posedge clock);
    #1;
    write = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] idx [5] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd31};
    #1 reset = 1'b0;
    #10;
    read_sel1 = 5'd31;
    read_sel2 = 5'd7;
    #1;
    tests_run++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held: rd1=%h rd2=%h expected 0/0", read_data1, read_data2);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      read_sel1 = idx[i];
      read_sel2 = idx[i];
      #1;
      tests_run++;
      if (read_data1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd1[%0d]: got %h expected 0", idx[i], read_data1);
      end
      tests_run++;
      if (read_data2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd2[%0d]: got %h expected 0", idx[i], read_data2);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd1, 32'd2);
    do_write(5'd3, 32'd5);
    do_write(5'd7, 32'd9);
    do_write(5'd5, 32'hA);
    read_sel1 = 5'd3;
    read_sel2 = 5'd1;
    #1;
    tests_run++;
    if (read_data1 !== 32'd5 || read_data2 !== 32'd2) begin
      tests_failed++;
      $display("FAIL wr_rd_3_1: got %h/%h expected 5/2", read_data1, read_data2);
    end
    read_sel1 = 5'd7;
    read_sel2 = 5'd7;
    #1;
    tests_run++;
    if (read_data1 !== 32'd9 || read_data2 !== 32'd9) begin
      tests_failed++;
      $display("FAIL wr_rd_7_7: got %h/%h expected 9/9", read_data1, read_data2);
    end
    read_sel1 = 5'd5;
    read_sel2 = 5'd31;
    #1;
    tests_run++;
    if (read_data1 !== 32'hA || read_data2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wr_rd_5_31: got %h/%h expected a/0", read_data1, read_data2);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'd7);
    read_sel1 = 5'd0;
    read_sel2 = 5'd7;
    #1;
    tests_run++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'd9) begin
      tests_failed++;
      $display("FAIL zero_rd1: got %h/%h expected 0/9", read_data1, read_data2);
    end
    read_sel1 = 5'd1;
    read_sel2 = 5'd0;
    #1;
    tests_run++;
    if (read_data1 !== 32'd2 || read_data2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_rd2: got %h/%h expected 2/0", read_data1, read_data2);
    end
  endtask

  task automatic test_write_enable();
    @(negedge clock);
    write      = 1'b0;
    write_sel  = 5'd5;
    write_data = 32'h1234;
    read_sel1  = 5'd5;
    @(posedge clock);
    #1;
    tests_run++;
    if (read_data1 !== 32'hA) begin
      tests_failed++;
      $display("FAIL write_disabled: got %h expected a", read_data1);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clock);
    write      = 1'b1;
    write_sel  = 5'd3;
    write_data = 32'h55;
    read_sel1  = 5'd3;
    read_sel2  = 5'd3;
    #1;
    tests_run++;
    if (read_data1 !== 32'd5) begin
      tests_failed++;
      $display("FAIL rdw_before: got %h expected 5", read_data1);
    end
    @(posedge clock);
    #1;
    write = 1'b0;
    tests_run++;
    if (read_data1 !== 32'h55 || read_data2 !== 32'h55) begin
      tests_failed++;
      $display("FAIL rdw_after: got %h/%h expected 55/55", read_data1, read_data2);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] idx [4] = '{5'd1, 5'd3, 5'd5, 5'd7};
    do_write(5'd31, 32'hDEADBEEF);
    read_sel2 = 5'd31;
    #1;
    tests_run++;
    if (read_data2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL pre_reset_31: got %h expected deadbeef", read_data2);
    end
    // Assert reset between edges; reads must clear before the next rising edge.
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (read_data2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_rd2_31: got %h expected 0", read_data2);
    end
    for (int i = 0; i < 4; i++) begin
      read_sel1 = idx[i];
      #1;
      tests_run++;
      if (read_data1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL async_rd1[%0d]: got %h expected 0", idx[i], read_data1);
      end
    end
    // Writes while reset is held are ignored.
    @(negedge clock);
    write      = 1'b1;
    write_sel  = 5'd7;
    write_data = 32'h77;
    read_sel1  = 5'd7;
    @(posedge clock);
    #1;
    tests_run++;
    if (read_data1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_in_reset: got %h expected 0", read_data1);
    end
    // First edge after release takes the pending write.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    write = 1'b0;
    tests_run++;
    if (read_data1 !== 32'h77) begin
      tests_failed++;
      $display("FAIL first_write_after_reset: got %h expected 77", read_data1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    write      = 1'b0;
    write_sel  = '0;
    write_data = '0;
    read_sel1  = '0;
    read_sel2  = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_write_enable();
    test_read_during_write();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_register_file
